// File: rtl/multicore_system_core_ram_loader.sv
// Boot-image loader: streams image words into a core's RAM port 2, then releases the core.
// Define CORE_RAM_LOADER_VERIFY_EN to build the readback-and-sum check.
module multicore_system_core_ram_loader #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        csr_address,
    input  logic              csr_write,
    input  logic [31:0]       csr_writedata,
    input  logic              csr_read,
    output logic [31:0]       csr_readdata,
    input  logic              snk_valid,
    input  logic [DATA_W-1:0] snk_data,
    input  logic              snk_endofpacket,
    output logic              snk_ready,
    output logic [ADDR_W-1:0] address2,
    output logic [DATA_W-1:0] writedata2,
    output logic [3:0]        byteenable2,
    output logic              chipselect2,
    output logic              write2,
    output logic              clken2,
    input  logic [DATA_W-1:0] readdata2,
    output logic              core_reset_req
);
    localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_VERIFY, S_DONE, S_ERROR} state_t;
    state_t state_q, state_d;

    logic [ADDR_W:0]   length_q, count_q;
    logic [DATA_W-1:0] sum_q;
    logic              err_short_q, err_len_q, last_q;
    logic              busy, start_req, len_ok, accept, last_word;
    logic              verify_go, verify_end, verify_ok, err_sum, rd_issue;
    logic [ADDR_W-1:0] rd_addr;
    logic [31:0]       status, csr_mux;
    logic              unused_wdata;

    assign busy           = (state_q == S_LOAD) || (state_q == S_VERIFY);
    assign start_req      = csr_write && (csr_address == 2'd0) && csr_writedata[0] && !busy;
    assign len_ok         = (length_q != '0) && (length_q <= DEPTH);
    // last_q holds LOAD one extra cycle so the final write lands before the core is released
    assign snk_ready      = (state_q == S_LOAD) && !last_q;
    assign accept         = snk_valid && snk_ready;
    assign last_word      = (count_q == length_q - ONE);
    assign byteenable2    = 4'hF;
    assign clken2         = busy;
    assign core_reset_req = (state_q != S_DONE);
    assign unused_wdata   = ^csr_writedata[31:ADDR_W+1];

`ifdef CORE_RAM_LOADER_VERIFY_EN
    logic              verify_q, err_sum_q;
    logic [ADDR_W:0]   rd_cnt_q;
    logic [DATA_W-1:0] rd_acc_q;
    logic              rd_vld_p0, rd_vld_p1, rd_last_p0, rd_last_p1;

    assign verify_go  = verify_q;
    assign rd_issue   = (state_q == S_VERIFY) && (rd_cnt_q != length_q);
    assign rd_addr    = rd_cnt_q[ADDR_W-1:0];
    assign verify_end = rd_vld_p1 && rd_last_p1;
    assign verify_ok  = ((rd_acc_q + readdata2) == sum_q);
    assign err_sum    = err_sum_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            verify_q   <= 1'b0;
            err_sum_q  <= 1'b0;
            rd_cnt_q   <= '0;
            rd_acc_q   <= '0;
            rd_vld_p0  <= 1'b0;
            rd_vld_p1  <= 1'b0;
            rd_last_p0 <= 1'b0;
            rd_last_p1 <= 1'b0;
        end else begin
            if (csr_write && (csr_address == 2'd0) && !busy)
                verify_q <= csr_writedata[1];
            // p0: read address on port 2; p1: RAM data returning on readdata2
            rd_vld_p0  <= rd_issue;
            rd_last_p0 <= rd_issue && (rd_cnt_q == length_q - ONE);
            rd_vld_p1  <= rd_vld_p0;
            rd_last_p1 <= rd_last_p0;
            if (rd_issue)
                rd_cnt_q <= rd_cnt_q + ONE;
            if (rd_vld_p1)
                rd_acc_q <= rd_acc_q + readdata2;
            if (start_req) begin
                rd_cnt_q  <= '0;
                rd_acc_q  <= '0;
                err_sum_q <= 1'b0;
            end else if (verify_end && !verify_ok) begin
                err_sum_q <= 1'b1;
            end
        end
    end
`else
    logic unused_rdata;

    assign verify_go    = 1'b0;
    assign verify_end   = 1'b0;
    assign verify_ok    = 1'b0;
    assign err_sum      = 1'b0;
    assign rd_issue     = 1'b0;
    assign rd_addr      = '0;
    assign unused_rdata = ^readdata2;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE, S_ERROR:
                if (start_req) state_d = len_ok ? S_LOAD : S_ERROR;
            S_LOAD:
                if (last_q)                         state_d = S_DONE;
                else if (accept && last_word)       state_d = verify_go ? S_VERIFY : S_LOAD;
                else if (accept && snk_endofpacket) state_d = S_ERROR;
            S_VERIFY:
                if (verify_end) state_d = verify_ok ? S_DONE : S_ERROR;
            default: state_d = S_IDLE;
        endcase
    end

    assign status = {16'(count_q), 11'd0, err_len_q, err_sum, err_short_q, (state_q == S_DONE), busy};

    always_comb begin
        csr_mux = '0;
        case (csr_address)
            2'd1:    csr_mux = 32'(length_q);
            2'd2:    csr_mux = status;
            2'd3:    csr_mux = 32'(sum_q);
            default: csr_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            length_q     <= '0;
            count_q      <= '0;
            sum_q        <= '0;
            err_short_q  <= 1'b0;
            err_len_q    <= 1'b0;
            last_q       <= 1'b0;
            csr_readdata <= '0;
        end else begin
            state_q <= state_d;
            if (csr_read)
                csr_readdata <= csr_mux;
            if (csr_write && (csr_address == 2'd1) && !busy)
                length_q <= csr_writedata[ADDR_W:0];
            if (start_req) begin
                count_q     <= '0;
                last_q      <= 1'b0;
                err_short_q <= 1'b0;
                err_len_q   <= !len_ok;
                if (len_ok)
                    sum_q <= '0;
            end else if (accept) begin
                count_q     <= count_q + ONE;
                sum_q       <= sum_q + snk_data;
                last_q      <= last_word && !verify_go;
                err_short_q <= !last_word && snk_endofpacket;
            end else if (last_q) begin
                last_q <= 1'b0;
            end
        end
    end

    // Port-2 strobes are registered: a word accepted this cycle is written next cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            address2    <= '0;
            writedata2  <= '0;
            chipselect2 <= 1'b0;
            write2      <= 1'b0;
        end else begin
            chipselect2 <= 1'b0;
            write2      <= 1'b0;
            if (accept) begin
                address2    <= count_q[ADDR_W-1:0];
                writedata2  <= snk_data;
                chipselect2 <= 1'b1;
                write2      <= 1'b1;
            end else if (rd_issue) begin
                address2    <= rd_addr;
                chipselect2 <= 1'b1;
            end
        end
    end
endmodule

// File: doc/multicore_system_core_ram_loader.md
# multicore_system_core_ram_loader

Boot-image loader that fills a core's dual-port program/data RAM through the RAM's second port before that core runs. It accepts a stream of 32-bit image words and writes them sequentially from word 0. It optionally reads the image back and checks its sum, then releases the core from reset. It sits directly upstream of the per-core dual-port RAM port 2, with its control slave on the system interconnect.

## Interface
- `ADDR_W`, 12, RAM word-address width (RAM depth = 2^ADDR_W words).
- `DATA_W`, 32, RAM/stream word width; byteenable is all-ones.
- `clk` in 1: single system clock; RAM port 2 is on the same clock.
- `reset` in 1: asynchronous, active-high reset.
- `csr_address` in 2: control-slave word address.
- `csr_write` in 1: CSR write strobe.
- `csr_writedata` in 32: CSR write data.
- `csr_read` in 1: CSR read strobe.
- `csr_readdata` out 32: CSR read data, registered, 1-cycle read latency.
- `snk_valid` in 1: image word valid.
- `snk_data` in 32: image word.
- `snk_endofpacket` in 1: last image word.
- `snk_ready` out 1: loader accepts a word this cycle.
- `address2` out ADDR_W: RAM port-2 word address.
- `writedata2` out 32: RAM port-2 write data.
- `byteenable2` out 4: constant 4'hF.
- `chipselect2` out 1: port-2 select.
- `write2` out 1: port-2 write.
- `clken2` out 1: port-2 clock enable. Held at 1 except in IDLE/DONE/ERROR.
- `readdata2` in 32: RAM port-2 read data, valid 1 cycle after address.
- `core_reset_req` out 1: holds the attached core in reset while 1.

## Operation
- CSR map:
  - 0 CTRL (W): bit0 START (self-clearing), bit1 VERIFY.
  - 1 LENGTH (R/W): image length in words, bits[ADDR_W:0]. Valid range 1..2^ADDR_W.
  - 2 STATUS (R): bit0 BUSY, bit1 DONE, bit2 ERR_SHORT, bit3 ERR_SUM, bit4 ERR_LEN, bits[31:16] word count.
  - 3 SUM (R): load-phase modulo-2^32 sum of accepted words.
- States: IDLE, LOAD, VERIFY, DONE, ERROR.
- IDLE → LOAD on START, if LENGTH is in range.
  - Entering LOAD clears count, SUM and error bits and asserts `core_reset_req`.
  - START with LENGTH of 0 or greater than 2^ADDR_W → ERROR with ERR_LEN set.
- LOAD:
  - `snk_ready` = 1.
  - Each cycle with `snk_valid`&`snk_ready`: write `snk_data` at `address2` = count; `chipselect2` = `write2` = 1; SUM += word; count++.
  - Writing the word with count == LENGTH−1 ends LOAD. If VERIFY is set, go to VERIFY; otherwise go to DONE.
  - `snk_endofpacket` on an earlier word → ERROR with ERR_SHORT set.
  - End-of-packet absent on the last word is not an error.
- VERIFY:
  - `snk_ready` = 0.
  - Issue reads on `address2` = 0..LENGTH−1, one per cycle, with `chipselect2` = 1 and `write2` = 0.
  - Accumulate `readdata2` one cycle after each address.
  - After the last datum: compare with SUM. Equal → DONE; otherwise → ERROR with ERR_SUM set.
- DONE:
  - `core_reset_req` = 0 and DONE = 1.
  - START re-enters LOAD and reasserts `core_reset_req` in the same cycle.
- ERROR:
  - `core_reset_req` stays 1.
  - START retries, clearing the error bits.
- START while BUSY is ignored. LENGTH writes while BUSY are ignored.
- Reset values:
  - State IDLE; `core_reset_req` = 1.
  - All RAM strobes 0; `address2` and `writedata2` = 0; `clken2` = 0.
  - `snk_ready` = 0; `csr_readdata` = 0; LENGTH = 0; SUM = 0; STATUS = 0.

## Timing
- Registered RAM outputs: a word accepted on cycle N is written at the clk edge ending cycle N+1.
- Load throughput is 1 word/cycle. Stalls track `snk_valid` only.
- Verify latency is LENGTH+2 cycles from the end of LOAD to DONE/ERROR.
- `core_reset_req` deasserts on the clk edge that enters DONE.
- A `reset` assertion mid-LOAD or mid-VERIFY aborts immediately to the reset values. The RAM contents are left as-is.
- A CSR read during a state transition returns the pre-edge STATUS.
- Address wrap: count never exceeds 2^ADDR_W−1. LENGTH = 2^ADDR_W fills the whole RAM exactly.

## Configuration
- `CORE_RAM_LOADER_VERIFY_EN` defined: the VERIFY state and readback accumulator are built, and CTRL bit1 is honoured.
- Not defined: VERIFY logic is absent and CTRL bit1 is ignored. LOAD goes straight to DONE, ERR_SUM reads 0, and `readdata2` is unused.

## Test plan
- LENGTH=4, START, words 1,2,3,4 (eop on 4), VERIFY=0 → RAM[0..3] = 1..4; SUM=10; DONE=1; `core_reset_req` falls 1 cycle after the last write.
- LENGTH=4, VERIFY=1, same words → 4 readback reads; DONE=1 at 6 cycles after the last write; ERR_SUM=0.
- LENGTH=8, eop on word 3 → ERROR, ERR_SHORT=1, `core_reset_req`=1, count=3.
- Test-bench corrupts RAM[2] during VERIFY → ERR_SUM=1; a subsequent START with a good image → DONE.
- LENGTH=0 START → ERR_LEN=1 and no RAM writes. LENGTH=4096 with back-to-back words → last write at address 4095, no wrap.
- `reset` asserted mid-LOAD at count=2 → all outputs return to reset values within the same cycle; `core_reset_req`=1; state IDLE.
